// File: rtl/des_key_schedule_seq.sv
// des_key_schedule_seq: iterative DES key schedule, one PC-2 subkey per handshake,
// in encrypt (K1..K16) or decrypt (K16..K1) order without storing the subkeys.
module des_key_schedule_seq #(
    parameter int KEY_W    = 64,
    parameter int SUBKEY_W = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_round,
    output logic                subkey_last,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                busy
);
    if (KEY_W != 64 || SUBKEY_W != 48) begin : g_bad_width
        $error("des_key_schedule_seq: KEY_W must be 64 and SUBKEY_W must be 48");
    end

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
        return o;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] h, input logic right, input logic two);
        return right ? (two ? {h[1:0], h[27:2]} : {h[0], h[27:1]})
                     : (two ? {h[25:0], h[27:26]} : {h[26:0], h[27]});
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_dec;
    logic [3:0]  r_cnt;
    logic [47:0] r_subkey;
    logic [55:0] w_pc1;
    logic [27:0] w_ld_c;
    logic [27:0] w_ld_d;
    logic [27:0] w_nx_c;
    logic [27:0] w_nx_d;
    logic        w_two;
    logic        w_load;
    logic        w_step;

    assign w_pc1  = pc1(key_in[63:0]);
    assign w_ld_c = decrypt ? w_pc1[55:28] : rot(w_pc1[55:28], 1'b0, 1'b0);
    assign w_ld_d = decrypt ? w_pc1[27:0]  : rot(w_pc1[27:0],  1'b0, 1'b0);
    // Next shift is s(count+2) encrypting, s(16-count) decrypting; both are 1 only at count 0, 7, 14
    assign w_two  = !(r_cnt == 4'd0 || r_cnt == 4'd7 || r_cnt == 4'd14);
    assign w_nx_c = rot(r_c, r_dec, w_two);
    assign w_nx_d = rot(r_d, r_dec, w_two);
    assign w_load = (r_state == IDLE) && key_valid;
    assign w_step = (r_state == RUN) && subkey_ready && (r_cnt != 4'd15);

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) w_state_nxt = RUN;
        if (r_state == RUN && subkey_ready && r_cnt == 4'd15) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c      <= '0;
            r_d      <= '0;
            r_dec    <= 1'b0;
            r_cnt    <= '0;
            r_subkey <= '0;
        end else if (w_load) begin
            r_c      <= w_ld_c;
            r_d      <= w_ld_d;
            r_dec    <= decrypt;
            r_cnt    <= '0;
            r_subkey <= pc2({w_ld_c, w_ld_d});
        end else if (w_step) begin
            r_c      <= w_nx_c;
            r_d      <= w_nx_d;
            r_cnt    <= r_cnt + 4'd1;
            r_subkey <= pc2({w_nx_c, w_nx_d});
        end
    end

    assign key_ready    = (r_state == IDLE);
    assign subkey_valid = (r_state == RUN);
    assign busy         = (r_state == RUN);
    assign subkey       = r_subkey;
    assign subkey_round = r_dec ? 4'd15 - r_cnt : r_cnt;
    assign subkey_last  = (r_state == RUN) && (r_cnt == 4'd15);
endmodule

// File: tb/tb_des_key_schedule_seq.sv
// tb_des_key_schedule_seq: directed checks of the DES key schedule against the
// published subkeys of key 133457799BBCDFF1.
module tb_des_key_schedule_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_last;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [47:0] KT [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule_seq dut (
        .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .key_valid(key_valid),
        .key_ready(key_ready), .subkey(subkey), .subkey_round(subkey_round),
        .subkey_last(subkey_last), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] key, input logic dec);
        int w = 0;
        while (!key_ready && w < 40) begin
            tick();
            w++;
        end
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_wait: key_ready=%b want 1", key_ready);
        end
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [55:0] act;
        rst = 1'b1;
        repeat (2) tick();
        act = {subkey_valid, busy, key_ready, subkey_last, subkey_round, subkey};
        total++;
        if (act !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 48'd0}) begin
            bad++;
            $display("FAIL reset: got %h want %h", act, {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 48'd0});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_schedule(input logic [63:0] key, input logic dec, input logic stall,
                                 input logic zk, input string name);
        int          n = 0;
        int          cyc = 0;
        int          hold = 0;
        logic        rdy;
        logic [3:0]  er;
        logic [55:0] exp;
        logic [55:0] act;
        load_key(key, dec);
        while (n < 16 && cyc < 300) begin
            rdy = 1'b1;
            if (stall) begin
                if (n == 7 && hold < 5) begin
                    rdy = 1'b0;
                    hold++;
                end else rdy = 1'($urandom_range(0, 1));
            end
            subkey_ready = rdy;
            er  = dec ? 4'(15 - n) : 4'(n);
            exp = {1'b1, 1'b1, 1'b0, (n == 15), er, zk ? 48'h0 : KT[er]};
            act = {subkey_valid, busy, key_ready, subkey_last, subkey_round, subkey};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL %s beat%0d: got %h want %h", name, n, act, exp);
            end
            tick();
            if (rdy) n++;
            cyc++;
        end
        subkey_ready = 1'b1;
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL %s timeout: accepted %0d want 16", name, n);
        end
        total++;
        if ({subkey_valid, busy, key_ready} !== 3'b001) begin
            bad++;
            $display("FAIL %s done: valid/busy/kready=%b want 001", name, {subkey_valid, busy, key_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] act;
        logic [55:0] exp;
        subkey_ready = 1'b1;
        key_in    = KEY_A;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        tick();
        decrypt = 1'b1;
        for (int n = 0; n < 16; n++) begin
            exp = {1'b1, 1'b1, 1'b0, (n == 15), 4'(n), KT[n]};
            act = {subkey_valid, busy, key_ready, subkey_last, subkey_round, subkey};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL b2b beat%0d: got %h want %h", n, act, exp);
            end
            tick();
        end
        total++;
        if ({subkey_valid, busy, key_ready} !== 3'b001) begin
            bad++;
            $display("FAIL b2b gap: valid/busy/kready=%b want 001", {subkey_valid, busy, key_ready});
        end
        tick();
        key_valid = 1'b0;
        act = {subkey_valid, busy, key_ready, subkey_last, subkey_round, subkey};
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 4'd15, KT[15]};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL b2b second_key: got %h want %h", act, exp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [55:0] act;
        load_key(KEY_A, 1'b0);
        subkey_ready = 1'b1;
        repeat (5) tick();
        total++;
        if (subkey_round !== 4'd5 || subkey !== KT[5]) begin
            bad++;
            $display("FAIL midrst_pre: round=%0d key=%h want 5 %h", subkey_round, subkey, KT[5]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        act = {subkey_valid, busy, key_ready, subkey_last, subkey_round, subkey};
        total++;
        if (act !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 48'd0}) begin
            bad++;
            $display("FAIL midrst: got %h want %h", act, {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 48'd0});
        end
        test_schedule(64'h0, 1'b0, 1'b0, 1'b1, "zero_key");
    endtask

    initial begin
        test_reset();
        test_schedule(KEY_A, 1'b0, 1'b0, 1'b0, "encrypt");
        test_schedule(KEY_A, 1'b1, 1'b0, 1'b0, "decrypt");
        test_schedule(KEY_A, 1'b0, 1'b1, 1'b0, "stall");
        test_back_to_back();
        test_mid_reset();
        // Flip the low bit of every byte: exactly the eight parity bits
        test_schedule(KEY_A ^ 64'h0101010101010101, 1'b0, 1'b0, 1'b0, "parity");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
